d_using_jk_reg: RTL and testbench

Word-wide D-type register built from a bank of JK flip-flops: a stream of target D words goes into a small FIFO, and each word is converted into J/K excitation vectors. The bank's state is then updated with the JK characteristic equation. This is the D-from-JK conversion, the counterpart of the team's JK-from-D flip-flop. It lets JK-based datapaths take D-style write streams, and exposes the excitations and a toggle-activity count for power and coverage analysis.

---
 rtl/d_using_jk_reg.sv | 118 +++++++++++
 tb/tb_d_using_jk_reg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_using_jk_reg.sv
// D-style write stream applied to a bank of JK flip-flops: a FIFO feeds a stage word,
// and the stage word is converted to J/K excitations that drive the JK characteristic update.
module d_using_jk_reg #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DC_POLICY = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_d,
  input  logic                     clr_stats,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         j_out,
  output logic [WIDTH-1:0]         k_out,
  output logic                     upd,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              toggles
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] stage_d;
  logic             stage_valid;
  logic             push;
  logic             pop;
  logic             apply;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic [WIDTH-1:0] q_next;
  logic [PW-1:0]    flips;
  logic [16:0]      tog_sum;

  assign in_ready = !reset && (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = en && (count != '0);
  assign apply    = en && stage_valid;

  // Excitation from the target word; both policies land q on stage_d.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (DC_POLICY == 1) begin
      j_vec = stage_d;
      k_vec = ~stage_d;
    end else begin
      j_vec = stage_d & ~q;
      k_vec = ~stage_d & q;
    end
    q_next = (j_vec & ~q) | (~k_vec & q);
    flips = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flips = flips + PW'(q[i] ^ q_next[i]);
    end
    tog_sum = {1'b0, toggles} + 17'(flips);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      stage_d     <= '0;
      stage_valid <= 1'b0;
      q           <= '0;
      j_out       <= '0;
      k_out       <= '0;
      upd         <= 1'b0;
      toggles     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        stage_d <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (en) begin
        stage_valid <= (count != '0);
      end
      if (apply) begin
        q     <= q_next;
        j_out <= j_vec;
        k_out <= k_vec;
        upd   <= 1'b1;
      end else begin
        j_out <= '0;
        k_out <= '0;
        upd   <= 1'b0;
      end
      // Clear wins over a coincident increment; the count sticks at all-ones.
      if (clr_stats) begin
        toggles <= '0;
      end else if (apply) begin
        toggles <= tog_sum[16] ? 16'hFFFF : tog_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_d_using_jk_reg.sv
// Directed bench for d_using_jk_reg: a minimal-excitation and a full-excitation instance
// share one stimulus stream; each scenario task checks its own hand-computed values.
module tb_d_using_jk_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       in_valid;
  logic [7:0] in_d;
  logic       clr_stats;

  logic       in_ready;
  logic [7:0] q;
  logic [7:0] j_out;
  logic [7:0] k_out;
  logic       upd;
  logic [2:0] count;
  logic [15:0] toggles;

  logic       in_ready1;
  logic [7:0] q1;
  logic [7:0] j_out1;
  logic [7:0] k_out1;
  logic       upd1;
  logic [2:0] count1;
  logic [15:0] toggles1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  d_using_jk_reg #(.WIDTH(8), .DEPTH(4), .DC_POLICY(0)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_d(in_d), .clr_stats(clr_stats), .q(q), .j_out(j_out), .k_out(k_out),
    .upd(upd), .count(count), .toggles(toggles)
  );

  d_using_jk_reg #(.WIDTH(8), .DEPTH(4), .DC_POLICY(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready1),
    .in_d(in_d), .clr_stats(clr_stats), .q(q1), .j_out(j_out1), .k_out(k_out1),
    .upd(upd1), .count(count1), .toggles(toggles1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_d = 8'h00; clr_stats = 1'b0;
    tick(); tick();
    total++; if (q !== 8'h00) begin bad++; $display("[TB] FAIL reset_q got=%h exp=00", q); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (upd !== 1'b0) begin bad++; $display("[TB] FAIL reset_upd got=%b exp=0", upd); end
    total++; if (toggles !== 16'h0) begin bad++; $display("[TB] FAIL reset_toggles got=%h exp=0000", toggles); end
    reset = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready got=%b exp=1", in_ready); end
    en = 1'b1; in_valid = 1'b1; in_d = 8'h33;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    total++; if (q !== 8'h33) begin bad++; $display("[TB] FAIL pre_reset_q got=%h exp=33", q); end
    in_valid = 1'b1; in_d = 8'hCC;
    tick();
    total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL pre_reset_count got=%0d exp=1", count); end
    #1 reset = 1'b1;
    #1;
    total++; if (q !== 8'h00) begin bad++; $display("[TB] FAIL mid_reset_q got=%h exp=00", q); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL mid_reset_count got=%0d exp=0", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_in_ready got=%b exp=0", in_ready); end
    total++; if (toggles !== 16'h0) begin bad++; $display("[TB] FAIL mid_reset_toggles got=%h exp=0000", toggles); end
    total++; if ({j_out, k_out, upd} !== 17'h0) begin bad++; $display("[TB] FAIL mid_reset_jku got=%h/%h/%b exp=0", j_out, k_out, upd); end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_d = 8'hA5;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (upd !== 1'b0) begin bad++; $display("[TB] FAIL single_early_upd got=%b exp=0", upd); end
    tick();
    total++; if (q !== 8'hA5) begin bad++; $display("[TB] FAIL single_q got=%h exp=a5", q); end
    total++; if (j_out !== 8'hA5) begin bad++; $display("[TB] FAIL single_j got=%h exp=a5", j_out); end
    total++; if (k_out !== 8'h00) begin bad++; $display("[TB] FAIL single_k got=%h exp=00", k_out); end
    total++; if (upd !== 1'b1) begin bad++; $display("[TB] FAIL single_upd got=%b exp=1", upd); end
    total++; if (toggles !== 16'd4) begin bad++; $display("[TB] FAIL single_toggles got=%0d exp=4", toggles); end
    total++; if (k_out1 !== 8'h5A) begin bad++; $display("[TB] FAIL single_p1_k got=%h exp=5a", k_out1); end
    tick();
    total++; if (upd !== 1'b0) begin bad++; $display("[TB] FAIL single_upd_pulse got=%b exp=0", upd); end
    total++; if (j_out !== 8'h00) begin bad++; $display("[TB] FAIL single_idle_j got=%h exp=00", j_out); end
    total++; if (q !== 8'hA5) begin bad++; $display("[TB] FAIL single_hold_q got=%h exp=a5", q); end
  endtask

  task automatic test_follow();
    in_valid = 1'b1; in_d = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    total++; if (q !== 8'h5A) begin bad++; $display("[TB] FAIL follow_q got=%h exp=5a", q); end
    total++; if (j_out !== 8'h5A) begin bad++; $display("[TB] FAIL follow_j got=%h exp=5a", j_out); end
    total++; if (k_out !== 8'hA5) begin bad++; $display("[TB] FAIL follow_k got=%h exp=a5", k_out); end
    total++; if (toggles !== 16'd12) begin bad++; $display("[TB] FAIL follow_toggles got=%0d exp=12", toggles); end
    in_valid = 1'b1; in_d = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    total++; if ({j_out, k_out} !== 16'h0) begin bad++; $display("[TB] FAIL repeat_jk got=%h/%h exp=00/00", j_out, k_out); end
    total++; if (upd !== 1'b1) begin bad++; $display("[TB] FAIL repeat_upd got=%b exp=1", upd); end
    total++; if (toggles !== 16'd12) begin bad++; $display("[TB] FAIL repeat_toggles got=%0d exp=12", toggles); end
  endtask

  task automatic test_policy1();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    in_valid = 1'b1; in_d = 8'h0F;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    total++; if (j_out1 !== 8'h0F) begin bad++; $display("[TB] FAIL p1_j got=%h exp=0f", j_out1); end
    total++; if (k_out1 !== 8'hF0) begin bad++; $display("[TB] FAIL p1_k got=%h exp=f0", k_out1); end
    total++; if (q1 !== 8'h0F) begin bad++; $display("[TB] FAIL p1_q got=%h exp=0f", q1); end
    total++; if (k_out !== 8'h00) begin bad++; $display("[TB] FAIL p0_k got=%h exp=00", k_out); end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int idx = 0;
    en = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_d = words[i];
      tick();
    end
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL bp_full_count got=%0d exp=4", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_ready got=%b exp=0", in_ready); end
    in_d = 8'h55;
    tick();
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL bp_fifth_count got=%0d exp=4", count); end
    in_valid = 1'b0; en = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_back got=%b exp=1", in_ready); end
    total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL bp_first_pop got=%0d exp=3", count); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (upd === 1'b1) begin
        total++;
        if (idx > 3) begin bad++; $display("[TB] FAIL bp_extra_upd got=%h exp=none", q); end
        else if (q !== words[idx]) begin bad++; $display("[TB] FAIL bp_order_%0d got=%h exp=%h", idx, q, words[idx]); end
        idx++;
      end
    end
    total++; if (idx != 4) begin bad++; $display("[TB] FAIL bp_upd_count got=%0d exp=4", idx); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_d = 8'h77;
    tick();
    in_valid = 1'b0;
    tick();
    en = 1'b0;
    tick(); tick();
    total++; if (upd !== 1'b0) begin bad++; $display("[TB] FAIL stall_upd got=%b exp=0", upd); end
    total++; if (q !== 8'h44) begin bad++; $display("[TB] FAIL stall_hold_q got=%h exp=44", q); end
    en = 1'b1;
    tick();
    total++; if (q !== 8'h77 || upd !== 1'b1) begin bad++; $display("[TB] FAIL stall_resume got=%h/%b exp=77/1", q, upd); end
  endtask

  task automatic test_saturation();
    int nupd = 0;
    in_valid = 1'b1; in_d = 8'h00;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    total++; if (toggles !== 16'h0 || q !== 8'h00) begin bad++; $display("[TB] FAIL sat_start got=%h/%h exp=0000/00", toggles, q); end
    in_valid = 1'b1;
    for (int i = 0; i < 8196; i++) begin
      in_d = i[0] ? 8'h00 : 8'hFF;
      tick();
      if (upd === 1'b1) begin
        nupd++;
        if (nupd == 8191) begin
          total++; if (toggles !== 16'hFFF8) begin bad++; $display("[TB] FAIL sat_pre got=%h exp=fff8", toggles); end
        end
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (upd === 1'b1) nupd++;
    end
    total++; if (nupd != 8196) begin bad++; $display("[TB] FAIL sat_updates got=%0d exp=8196", nupd); end
    total++; if (toggles !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_hold got=%h exp=ffff", toggles); end
    in_valid = 1'b1; in_d = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    total++; if (upd !== 1'b1 || q !== 8'hFF) begin bad++; $display("[TB] FAIL clr_update got=%b/%h exp=1/ff", upd, q); end
    total++; if (toggles !== 16'h0) begin bad++; $display("[TB] FAIL clr_priority got=%h exp=0000", toggles); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int idx = 1;
    en = 1'b0; in_valid = 1'b1;
    in_d = 8'hA1; tick();
    in_d = 8'hA2; tick();
    total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL b2b_fill got=%0d exp=2", count); end
    en = 1'b1; in_d = 8'hA3;
    tick();
    total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL b2b_pushpop1 got=%0d exp=2", count); end
    in_d = 8'hA4;
    tick();
    total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL b2b_pushpop2 got=%0d exp=2", count); end
    total++; if (q !== 8'hA1 || upd !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first got=%h/%b exp=a1/1", q, upd); end
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (upd === 1'b1) begin
        total++;
        if (idx > 3) begin bad++; $display("[TB] FAIL b2b_extra_upd got=%h exp=none", q); end
        else if (q !== exp_q[idx]) begin bad++; $display("[TB] FAIL b2b_order_%0d got=%h exp=%h", idx, q, exp_q[idx]); end
        idx++;
      end
    end
    total++; if (idx != 4) begin bad++; $display("[TB] FAIL b2b_upd_count got=%0d exp=4", idx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_follow();
    test_policy1();
    test_backpressure();
    test_stall();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
